// File: rtl/dsram_port_arbiter_pkg.sv
// Shared definitions for the data-SRAM port arbiter and MEM-side logic.
//   MASTER0 / MASTER1 : master index encoding (used for read-owner tracking)
//   ADDR_W_DEF / DATA_W_DEF : default address / data widths
//   STARVE_CNT_W : width of the master-1 starvation counter (limit 1..15)
//   sram_req_t : SRAM request bundle at default widths (en, we, addr, wdata)
package dsram_port_arbiter_pkg;

  localparam logic MASTER0 = 1'b0;
  localparam logic MASTER1 = 1'b1;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int STARVE_CNT_W = 4;

  typedef struct packed {
    logic                    en;
    logic [DATA_W_DEF/8-1:0] we;
    logic [ADDR_W_DEF-1:0]   addr;
    logic [DATA_W_DEF-1:0]   wdata;
  } sram_req_t;

endpackage

// File: rtl/dsram_starve_counter.sv
// Starvation guard for master 1 of the data-SRAM port arbiter.
// Counts consecutive cycles in which master 1 requests but is not granted,
// saturating at STARVE_LIMIT; o_force1 asks the arbiter to hand master 1
// the port regardless of master 0.
// Ports:
//   clk, reset  : clock, synchronous active-high reset
//   i_m1_req    : master 1 request
//   i_m1_gnt    : master 1 granted this cycle
//   o_force1    : master 1 must be granted this cycle
//   o_cnt       : current counter value (debug visibility)
module dsram_starve_counter
  import dsram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_m1_req,
  input  logic                    i_m1_gnt,
  output logic                    o_force1,
  output logic [STARVE_CNT_W-1:0] o_cnt
);

  localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

  logic [STARVE_CNT_W-1:0] r_cnt;

  // Any grant or any gap in the request restarts the denial window.
  always_ff @(posedge clk) begin
    if (reset || !i_m1_req || i_m1_gnt) begin
      r_cnt <= '0;
    end else if (r_cnt != LIMIT) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_force1 = i_m1_req && (r_cnt == LIMIT);
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/dsram_port_arbiter.sv
// Arbiter sharing the single synchronous data-SRAM port between master 0
// (EXE-stage load/store) and master 1 (debug/DMA/refill).
// Fixed priority to master 0 with a starvation guard for master 1; read data
// (1-cycle latency) is routed back to whichever master issued the read.
// Handshake: a master holds req/we/addr/wdata stable until it sees gnt high
// in the same cycle; gnt means the access was issued to the SRAM that cycle.
// Reads return mX_rvalid exactly one cycle after the grant; writes return
// nothing. The arbiter never latches requests.
// Ports:
//   clk, reset                         : clock, synchronous active-high reset
//   m0_req/we/addr/wdata               : master 0 request (we == 0 -> read)
//   m0_gnt, m0_stall                   : master 0 grant, EXE-stage stall
//   m0_rvalid, m0_rdata                : master 0 read return
//   m1_req/we/addr/wdata               : master 1 request
//   m1_gnt, m1_rvalid, m1_rdata        : master 1 grant and read return
//   sram_en/we/addr/wdata, sram_rdata  : SRAM port
//   dbg_starve_cnt                     : starvation counter state
module dsram_port_arbiter
  import dsram_port_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    m0_req,
  input  logic [DATA_W/8-1:0]     m0_we,
  input  logic [ADDR_W-1:0]       m0_addr,
  input  logic [DATA_W-1:0]       m0_wdata,
  output logic                    m0_gnt,
  output logic                    m0_stall,
  output logic                    m0_rvalid,
  output logic [DATA_W-1:0]       m0_rdata,
  input  logic                    m1_req,
  input  logic [DATA_W/8-1:0]     m1_we,
  input  logic [ADDR_W-1:0]       m1_addr,
  input  logic [DATA_W-1:0]       m1_wdata,
  output logic                    m1_gnt,
  output logic                    m1_rvalid,
  output logic [DATA_W-1:0]       m1_rdata,
  output logic                    sram_en,
  output logic [DATA_W/8-1:0]     sram_we,
  output logic [ADDR_W-1:0]       sram_addr,
  output logic [DATA_W-1:0]       sram_wdata,
  input  logic [DATA_W-1:0]       sram_rdata,
  output logic [STARVE_CNT_W-1:0] dbg_starve_cnt
);

  localparam int BE_W = DATA_W / 8;

  typedef struct packed {
    logic              en;
    logic [BE_W-1:0]   we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_bundle_t;

  logic        w_force1;
  logic        w_m0_gnt;
  logic        w_m1_gnt;
  logic        w_rd_grant;
  req_bundle_t w_sram_req;
  logic        r_rd_pend;
  logic        r_rd_owner;

  dsram_starve_counter #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .reset    (reset),
    .i_m1_req (m1_req),
    .i_m1_gnt (w_m1_gnt),
    .o_force1 (w_force1),
    .o_cnt    (dbg_starve_cnt)
  );

  // Grants are suppressed while reset is high so nothing reaches the SRAM.
  // w_force1 already implies m1_req, so the two grants are exclusive.
  assign w_m0_gnt = !reset && m0_req && !w_force1;
  assign w_m1_gnt = !reset && m1_req && (!m0_req || w_force1);

  always_comb begin
    w_sram_req = '0;
    if (w_m0_gnt) begin
      w_sram_req.en    = 1'b1;
      w_sram_req.we    = m0_we;
      w_sram_req.addr  = m0_addr;
      w_sram_req.wdata = m0_wdata;
    end else if (w_m1_gnt) begin
      w_sram_req.en    = 1'b1;
      w_sram_req.we    = m1_we;
      w_sram_req.addr  = m1_addr;
      w_sram_req.wdata = m1_wdata;
    end
  end

  assign w_rd_grant = w_sram_req.en && (w_sram_req.we == '0);

  // Remember who issued a read so the next-cycle data goes to the right master.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rd_pend  <= 1'b0;
      r_rd_owner <= MASTER0;
    end else begin
      r_rd_pend <= w_rd_grant;
      if (w_sram_req.en) begin
        r_rd_owner <= w_m1_gnt ? MASTER1 : MASTER0;
      end
    end
  end

  assign m0_gnt     = w_m0_gnt;
  assign m1_gnt     = w_m1_gnt;
  assign m0_stall   = m0_req && !w_m0_gnt;
  assign m0_rvalid  = r_rd_pend && (r_rd_owner == MASTER0);
  assign m1_rvalid  = r_rd_pend && (r_rd_owner == MASTER1);
  assign m0_rdata   = sram_rdata;
  assign m1_rdata   = sram_rdata;
  assign sram_en    = w_sram_req.en;
  assign sram_we    = w_sram_req.we;
  assign sram_addr  = w_sram_req.addr;
  assign sram_wdata = w_sram_req.wdata;

endmodule

// File: tb/tb_dsram_port_arbiter.sv
// Directed testbench for dsram_port_arbiter (default parameters,
// STARVE_LIMIT = 4). Inputs change just after the falling edge and outputs
// are sampled 1 ns later, well away from the rising (active) edge.
module tb_dsram_port_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req;
  logic [3:0]  m0_we;
  logic [31:0] m0_addr;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_stall;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req;
  logic [3:0]  m1_we;
  logic [31:0] m1_addr;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        sram_en;
  logic [3:0]  sram_we;
  logic [31:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata;
  logic [3:0]  dbg_starve_cnt;

  int checks   = 0;
  int failures = 0;

  dsram_port_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .m0_req         (m0_req),
    .m0_we          (m0_we),
    .m0_addr        (m0_addr),
    .m0_wdata       (m0_wdata),
    .m0_gnt         (m0_gnt),
    .m0_stall       (m0_stall),
    .m0_rvalid      (m0_rvalid),
    .m0_rdata       (m0_rdata),
    .m1_req         (m1_req),
    .m1_we          (m1_we),
    .m1_addr        (m1_addr),
    .m1_wdata       (m1_wdata),
    .m1_gnt         (m1_gnt),
    .m1_rvalid      (m1_rvalid),
    .m1_rdata       (m1_rdata),
    .sram_en        (sram_en),
    .sram_we        (sram_we),
    .sram_addr      (sram_addr),
    .sram_wdata     (sram_wdata),
    .sram_rdata     (sram_rdata),
    .dbg_starve_cnt (dbg_starve_cnt)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard
  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic drive_m0(input logic req, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m0_req   = req;
    m0_we    = we;
    m0_addr  = addr;
    m0_wdata = wdata;
  endtask

  task automatic drive_m1(input logic req, input logic [3:0] we,
                          input logic [31:0] addr, input logic [31:0] wdata);
    m1_req   = req;
    m1_we    = we;
    m1_addr  = addr;
    m1_wdata = wdata;
  endtask

  task automatic idle_both();
    drive_m0(1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b0, 4'h0, 32'h0, 32'h0);
  endtask

  initial begin
    logic       exp_m1;
    logic       prev_m1;
    logic [3:0] exp_cnt;

    reset      = 1'b1;
    sram_rdata = 32'h0;
    idle_both();

    // ---------------- reset behaviour ----------------
    cyc();
    drive_m0(1'b1, 4'h0, 32'h1C000100, 32'h0);
    drive_m1(1'b1, 4'h0, 32'h200, 32'h0);
    settle();
    check("rst_m0_gnt", m0_gnt, 1'b0);
    check("rst_m1_gnt", m1_gnt, 1'b0);
    check("rst_sram_en", sram_en, 1'b0);
    check("rst_sram_addr", sram_addr, 32'h0);
    check("rst_m0_rvalid", m0_rvalid, 1'b0);
    check("rst_m1_rvalid", m1_rvalid, 1'b0);
    check("rst_cnt", dbg_starve_cnt, 4'd0);

    // ---------------- m0 read only ----------------
    cyc();
    reset = 1'b0;
    idle_both();
    drive_m0(1'b1, 4'h0, 32'h1C000100, 32'h0);
    settle();
    check("rd0_m0_gnt", m0_gnt, 1'b1);
    check("rd0_m1_gnt", m1_gnt, 1'b0);
    check("rd0_stall", m0_stall, 1'b0);
    check("rd0_sram_en", sram_en, 1'b1);
    check("rd0_sram_addr", sram_addr, 32'h1C000100);
    check("rd0_sram_we", sram_we, 4'h0);

    cyc();
    idle_both();
    sram_rdata = 32'hCAFE0001;
    settle();
    check("rd0_m0_rvalid", m0_rvalid, 1'b1);
    check("rd0_m0_rdata", m0_rdata, 32'hCAFE0001);
    check("rd0_m1_rvalid", m1_rvalid, 1'b0);
    check("rd0_idle_en", sram_en, 1'b0);
    check("rd0_idle_addr", sram_addr, 32'h0);

    // ---------------- contention, continuous reads ----------------
    // Counter starts at 0; m1 is forced on every fifth cycle (indices 4, 9).
    prev_m1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      cyc();
      drive_m0(1'b1, 4'h0, 32'h100, 32'h0);
      drive_m1(1'b1, 4'h0, 32'h200, 32'h0);
      settle();
      exp_m1  = ((i % 5) == 4);
      exp_cnt = 4'(i % 5);
      check("ct_m0_gnt", m0_gnt, !exp_m1);
      check("ct_m1_gnt", m1_gnt, exp_m1);
      check("ct_stall", m0_stall, exp_m1);
      check("ct_addr", sram_addr, (exp_m1 ? 32'h200 : 32'h100));
      check("ct_cnt", dbg_starve_cnt, exp_cnt);
      check("ct_m1_rvalid", m1_rvalid, (i > 0) && prev_m1);
      check("ct_m0_rvalid", m0_rvalid, (i > 0) && !prev_m1);
      prev_m1 = exp_m1;
    end
    cyc();
    idle_both();
    settle();
    check("ct_tail_m1_rvalid", m1_rvalid, 1'b1);
    check("ct_tail_m0_rvalid", m0_rvalid, 1'b0);
    check("ct_tail_cnt", dbg_starve_cnt, 4'd0);

    // ---------------- m1 write then read ----------------
    cyc();
    drive_m1(1'b1, 4'hF, 32'h40, 32'hDEADBEEF);
    settle();
    check("wr_m1_gnt", m1_gnt, 1'b1);
    check("wr_sram_we", sram_we, 4'hF);
    check("wr_sram_addr", sram_addr, 32'h40);
    check("wr_sram_wdata", sram_wdata, 32'hDEADBEEF);

    cyc();
    drive_m1(1'b1, 4'h0, 32'h40, 32'h0);
    settle();
    check("wr_no_m1_rvalid", m1_rvalid, 1'b0);
    check("wr_no_m0_rvalid", m0_rvalid, 1'b0);
    check("rd1_m1_gnt", m1_gnt, 1'b1);
    check("rd1_sram_we", sram_we, 4'h0);

    cyc();
    idle_both();
    sram_rdata = 32'hDEADBEEF;
    settle();
    check("rd1_m1_rvalid", m1_rvalid, 1'b1);
    check("rd1_m1_rdata", m1_rdata, 32'hDEADBEEF);
    check("rd1_m0_rvalid", m0_rvalid, 1'b0);

    // ---------------- alternating owners ----------------
    cyc();
    drive_m0(1'b1, 4'h0, 32'h8, 32'h0);
    settle();
    check("alt_m0_gnt", m0_gnt, 1'b1);

    cyc();
    drive_m0(1'b0, 4'h0, 32'h0, 32'h0);
    drive_m1(1'b1, 4'h0, 32'hC, 32'h0);
    settle();
    check("alt_m1_gnt", m1_gnt, 1'b1);
    check("alt_n1_m0_rvalid", m0_rvalid, 1'b1);
    check("alt_n1_m1_rvalid", m1_rvalid, 1'b0);

    cyc();
    idle_both();
    settle();
    check("alt_n2_m1_rvalid", m1_rvalid, 1'b1);
    check("alt_n2_m0_rvalid", m0_rvalid, 1'b0);

    // ---------------- starve counter clear ----------------
    for (int k = 0; k < 3; k++) begin
      cyc();
      drive_m0(1'b1, 4'h0, 32'h300, 32'h0);
      drive_m1(1'b1, 4'h0, 32'h400, 32'h0);
      settle();
      check("sc_deny_m1_gnt", m1_gnt, 1'b0);
      check("sc_deny_cnt", dbg_starve_cnt, 4'(k));
    end
    cyc();
    drive_m1(1'b0, 4'h0, 32'h0, 32'h0);
    settle();
    check("sc_drop_cnt", dbg_starve_cnt, 4'd3);
    check("sc_drop_m0_gnt", m0_gnt, 1'b1);
    for (int j = 0; j < 5; j++) begin
      cyc();
      drive_m1(1'b1, 4'h0, 32'h400, 32'h0);
      settle();
      exp_m1 = (j == 4);
      check("sc_re_cnt", dbg_starve_cnt, 4'(j));
      check("sc_re_m1_gnt", m1_gnt, exp_m1);
      check("sc_re_m0_gnt", m0_gnt, !exp_m1);
      check("sc_re_stall", m0_stall, exp_m1);
    end

    // ---------------- reset mid-operation ----------------
    // Counter is 0 after the forced grant; build it up again to 2.
    for (int k = 0; k < 2; k++) begin
      cyc();
      drive_m0(1'b1, 4'h0, 32'h500, 32'h0);
      drive_m1(1'b1, 4'h0, 32'h600, 32'h0);
      settle();
      check("rm_pre_m0_gnt", m0_gnt, 1'b1);
    end
    cyc();
    reset = 1'b1;
    settle();
    check("rm_cnt_before", dbg_starve_cnt, 4'd2);
    check("rm_m0_rvalid_prev", m0_rvalid, 1'b1);
    check("rm_m0_gnt", m0_gnt, 1'b0);
    check("rm_m1_gnt", m1_gnt, 1'b0);
    check("rm_sram_en", sram_en, 1'b0);
    check("rm_sram_addr", sram_addr, 32'h0);

    cyc();
    reset = 1'b0;
    idle_both();
    settle();
    check("rm_after_m0_rvalid", m0_rvalid, 1'b0);
    check("rm_after_m1_rvalid", m1_rvalid, 1'b0);
    check("rm_after_cnt", dbg_starve_cnt, 4'd0);

    // Arbiter works normally again after reset
    cyc();
    drive_m1(1'b1, 4'h0, 32'h700, 32'h0);
    settle();
    check("post_m1_gnt", m1_gnt, 1'b1);
    check("post_sram_addr", sram_addr, 32'h700);

    cyc();
    idle_both();
    settle();
    check("post_m1_rvalid", m1_rvalid, 1'b1);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dsram_port_arbiter.md
Name: dsram_port_arbiter

Overview:
- Shares the single synchronous data SRAM port between two requesters.
- Master 0 is the EXE-stage load/store path; master 1 is a secondary master (debug/DMA/refill).
- Per-cycle fixed-priority arbitration with a starvation guard for master 1.
- Routes 1-cycle-latency read data back to the owning master.
- Generates the EXE-stage stall when master 0 loses arbitration.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; byte-enable width is DATA_W/8.
- STARVE_LIMIT, 4, number of consecutive cycles master 1 may be denied before it is force-granted; range 1..15.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- m0_req  in  1  master 0 access request.
- m0_we  in  DATA_W/8  master 0 byte write enables; 0 = read.
- m0_addr  in  ADDR_W  master 0 address.
- m0_wdata  in  DATA_W  master 0 write data.
- m0_gnt  out  1  master 0 access issued to SRAM this cycle.
- m0_stall  out  1  m0_req && !m0_gnt; drives the EXE-stage stall input.
- m0_rvalid  out  1  master 0 read data valid.
- m0_rdata  out  DATA_W  master 0 read data.
- m1_req, m1_we, m1_addr, m1_wdata  in  same widths as master 0  master 1 request.
- m1_gnt  out  1  master 1 access issued to SRAM this cycle.
- m1_rvalid  out  1  master 1 read data valid.
- m1_rdata  out  DATA_W  master 1 read data.
- sram_en  out  1  SRAM enable.
- sram_we  out  DATA_W/8  SRAM byte write enables.
- sram_addr  out  ADDR_W  SRAM address.
- sram_wdata  out  DATA_W  SRAM write data.
- sram_rdata  in  DATA_W  SRAM read data, valid the cycle after an enabled read.

Behaviour:
- Grant logic is combinational from current requests and registered state. At most one of m0_gnt/m1_gnt is high per cycle.
- Default priority is master 0: m0_gnt = m0_req && !force1.
- m1_gnt = m1_req && (!m0_req || force1).
- force1 = m1_req && (starve_cnt == STARVE_LIMIT).
- starve_cnt is a registered counter.
  - Increments by 1 when m1_req && !m1_gnt.
  - Saturates at STARVE_LIMIT.
  - Clears to 0 on m1_gnt or when !m1_req.
- SRAM mux:
  - sram_en = m0_gnt | m1_gnt.
  - sram_we/addr/wdata come from the granted master.
  - When neither master is granted, sram_we = 0, addr = 0 and wdata = 0.
- Requesters hold req/we/addr/wdata stable until they see gnt; the arbiter does not latch requests.
- Read response tracking:
  - Registers rd_pend and rd_owner.
  - rd_pend is set when a grant is a read (we == 0); otherwise it is cleared.
  - rd_owner records the granted master index.
- Read data return:
  - Next cycle, mX_rvalid = rd_pend && (rd_owner == X).
  - m0_rdata and m1_rdata both carry sram_rdata unconditionally; consumers qualify with rvalid.
- Latency:
  - Grant in cycle N; read data valid in cycle N+1.
  - Back-to-back grants every cycle are allowed, so throughput is 1 access/cycle.
- Writes produce no rvalid.
- Simultaneous requests: master 0 wins unless force1. A forced grant to master 1 stalls master 0 for exactly that one cycle.
- Reset (synchronous; applies mid-operation too):
  - starve_cnt = 0, rd_pend = 0, rd_owner = 0.
  - m0_rvalid = m1_rvalid = 0 in the cycle after reset is sampled.
  - A read granted in the same cycle as reset yields no rvalid.
- While reset is high, grants and sram_en are forced to 0.

Decomposition:
- Shared package holds:
  - constants MASTER0 = 0 and MASTER1 = 1;
  - default ADDR_W/DATA_W;
  - the SRAM request bundle typedef (en, we, addr, wdata), reused by MEM-side logic.
- One sub-module: dsram_starve_counter.
  - Contains the saturating counter and the force1 compare.
  - Parameterised by STARVE_LIMIT.

Test Plan:
- m0 read only: m0_req=1, we=0, addr=0x1C000100 in cycle N.
  - Cycle N: m0_gnt=1, sram_en=1, sram_addr=0x1C000100.
  - Cycle N+1: m0_rvalid=1, m0_rdata=sram_rdata; m1_rvalid=0.
- Contention: m0 and m1 both request reads continuously, STARVE_LIMIT=4.
  - Master 0 is granted 4 cycles, then master 1 is granted in the 5th; the pattern repeats.
  - m0_stall=1 only in the forced cycles.
  - Each m1_rvalid follows its m1_gnt by exactly one cycle.
- Write then read: m1 write we=4'b1111, addr=0x40, wdata=0xDEADBEEF with m0 idle; next cycle m1 read addr=0x40.
  - Write cycle: m1_gnt=1, sram_we=4'hF; no rvalid follows it.
  - Read: m1_rvalid=1 one cycle after its grant.
- Alternating owners back-to-back: m0 read in cycle N, m1 read in cycle N+1 (m0 idle).
  - Cycle N+1: m0_rvalid=1.
  - Cycle N+2: m1_rvalid=1.
  - Never both rvalids high in the same cycle.
- Starve counter clear: m1 is denied 3 cycles, drops m1_req for 1 cycle, then re-asserts with m0 busy.
  - The counter restarts at 0; a forced grant happens only after 4 further denials.
- Reset mid-operation: m0 read granted in cycle N with reset=1 in cycle N.
  - Cycle N+1: m0_rvalid=0, starve_cnt=0.
  - During reset: sram_en=0, all gnt=0.
